// File: rtl/ps2_scan_code_assembler.sv
// Turns the PS/2 receiver's byte stream into complete make/break scan-code
// sequences (plain, F0, E0, E0 F0), emitted right-aligned on key_code.
module ps2_scan_code_assembler #(
  parameter logic [31:0] TimeoutCycles = 32'd250000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  input  logic        byte_error,
  output logic [23:0] key_code,
  output logic        key_valid,
  output logic        key_break,
  output logic        key_extended,
  output logic        sequence_error,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GOT_E0  = 2'd1;
  localparam logic [1:0] ST_GOT_F0  = 2'd2;
  localparam logic [1:0] ST_GOT_E0F0 = 2'd3;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  logic [1:0]  r_state;
  logic [31:0] r_gap;
  logic [23:0] r_key_code;
  logic        r_key_valid;
  logic        r_key_break;
  logic        r_key_extended;
  logic        r_seq_error;
  logic        r_busy;

  logic [31:0] w_gap_max;
  logic        w_is_prefix;
  logic        w_timeout;
  logic [1:0]  w_next_state;
  logic        w_emit;
  logic [23:0] w_emit_code;
  logic        w_emit_break;
  logic        w_emit_ext;
  logic        w_seq_error;

  assign w_gap_max   = TimeoutCycles - 32'd1;
  assign w_is_prefix = (byte_data == PFX_EXT) || (byte_data == PFX_BRK);
  // A byte arriving on the timeout cycle takes precedence over the timeout.
  assign w_timeout   = (r_state != ST_IDLE) && (r_gap == w_gap_max) && !byte_valid;

  always_comb begin
    w_next_state = r_state;
    w_emit       = 1'b0;
    w_emit_code  = 24'h000000;
    w_emit_break = 1'b0;
    w_emit_ext   = 1'b0;
    w_seq_error  = 1'b0;

    if (byte_error) begin
      w_seq_error  = 1'b1;
      w_next_state = ST_IDLE;
    end else if (byte_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (byte_data == PFX_EXT) begin
            w_next_state = ST_GOT_E0;
          end else if (byte_data == PFX_BRK) begin
            w_next_state = ST_GOT_F0;
          end else begin
            w_emit      = 1'b1;
            w_emit_code = {16'h0000, byte_data};
          end
        end
        ST_GOT_E0: begin
          if (byte_data == PFX_BRK) begin
            w_next_state = ST_GOT_E0F0;
          end else if (byte_data == PFX_EXT) begin
            // Repeated E0 restarts the extended prefix rather than returning to IDLE.
            w_seq_error  = 1'b1;
            w_next_state = ST_GOT_E0;
          end else begin
            w_emit       = 1'b1;
            w_emit_code  = {8'h00, PFX_EXT, byte_data};
            w_emit_ext   = 1'b1;
            w_next_state = ST_IDLE;
          end
        end
        ST_GOT_F0: begin
          w_next_state = ST_IDLE;
          if (w_is_prefix) begin
            w_seq_error = 1'b1;
          end else begin
            w_emit       = 1'b1;
            w_emit_code  = {8'h00, PFX_BRK, byte_data};
            w_emit_break = 1'b1;
          end
        end
        default: begin
          w_next_state = ST_IDLE;
          if (w_is_prefix) begin
            w_seq_error = 1'b1;
          end else begin
            w_emit       = 1'b1;
            w_emit_code  = {PFX_EXT, PFX_BRK, byte_data};
            w_emit_break = 1'b1;
            w_emit_ext   = 1'b1;
          end
        end
      endcase
    end else if (w_timeout) begin
      w_seq_error  = 1'b1;
      w_next_state = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_gap          <= 32'd0;
      r_key_code     <= 24'h000000;
      r_key_valid    <= 1'b0;
      r_key_break    <= 1'b0;
      r_key_extended <= 1'b0;
      r_seq_error    <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_busy      <= (w_next_state != ST_IDLE);
      r_key_valid <= w_emit;
      r_seq_error <= w_seq_error;

      if (w_emit) begin
        r_key_code     <= w_emit_code;
        r_key_break    <= w_emit_break;
        r_key_extended <= w_emit_ext;
      end

      // Gap counter only runs while a sequence is partially assembled.
      if (byte_valid || byte_error || (r_state == ST_IDLE)) begin
        r_gap <= 32'd0;
      end else if (r_gap != w_gap_max) begin
        r_gap <= r_gap + 32'd1;
      end
    end
  end

  assign key_code       = r_key_code;
  assign key_valid      = r_key_valid;
  assign key_break      = r_key_break;
  assign key_extended   = r_key_extended;
  assign sequence_error = r_seq_error;
  assign busy           = r_busy;

endmodule

// File: tb/tb_ps2_scan_code_assembler.sv
// Directed bench for ps2_scan_code_assembler: per-cycle vector table plus
// hand-written timeout sequences, with TimeoutCycles shortened to 16.
module tb_ps2_scan_code_assembler;

  localparam int TO = 16;

  logic        clk;
  logic        rst;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_error;
  logic [23:0] key_code;
  logic        key_valid;
  logic        key_break;
  logic        key_extended;
  logic        sequence_error;
  logic        busy;

  int n_pass;
  int n_total;

  ps2_scan_code_assembler #(.TimeoutCycles(32'd16)) dut (
    .clk            (clk),
    .rst            (rst),
    .byte_data      (byte_data),
    .byte_valid     (byte_valid),
    .byte_error     (byte_error),
    .key_code       (key_code),
    .key_valid      (key_valid),
    .key_break      (key_break),
    .key_extended   (key_extended),
    .sequence_error (sequence_error),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        v;
    logic        e;
    logic [7:0]  d;
    logic        kv;
    logic [23:0] kc;
    logic        kb;
    logic        ke;
    logic        se;
    logic        bz;
    string       name;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, input logic v, input logic e, input logic [7:0] d,
                              input logic kv, input logic [23:0] kc, input logic kb,
                              input logic ke, input logic se, input logic bz, input string name);
    vec_t t;
    t.r = r; t.v = v; t.e = e; t.d = d;
    t.kv = kv; t.kc = kc; t.kb = kb; t.ke = ke; t.se = se; t.bz = bz;
    t.name = name;
    return t;
  endfunction

  // Drive one cycle of inputs, then check the registered outputs 1 ns after the edge.
  task automatic step(input logic r, input logic v, input logic e, input logic [7:0] d,
                      input logic [28:0] exp, input string name);
    logic [28:0] act;
    rst = r; byte_valid = v; byte_error = e; byte_data = d;
    @(posedge clk);
    #1;
    act = {key_valid, key_code, key_break, key_extended, sequence_error, busy};
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got kv=%b kc=%h kb=%b ke=%b se=%b busy=%b, want kv=%b kc=%h kb=%b ke=%b se=%b busy=%b",
                  name, act[28], act[27:4], act[3], act[2], act[1], act[0],
                  exp[28], exp[27:4], exp[3], exp[2], exp[1], exp[0]);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b1; byte_valid = 1'b0; byte_error = 1'b0; byte_data = 8'h00;

    //              r  v  e  data   kv  key_code    kb ke se bz
    vq.push_back(mk(1, 0, 0, 8'h00, 0, 24'h000000, 0, 0, 0, 0, "reset0"));
    vq.push_back(mk(1, 0, 0, 8'h00, 0, 24'h000000, 0, 0, 0, 0, "reset1"));
    vq.push_back(mk(0, 1, 0, 8'h1C, 1, 24'h00001C, 0, 0, 0, 0, "make_1C"));
    vq.push_back(mk(0, 0, 0, 8'h00, 0, 24'h00001C, 0, 0, 0, 0, "hold_1C"));
    vq.push_back(mk(0, 1, 0, 8'hE0, 0, 24'h00001C, 0, 0, 0, 1, "ext_brk_E0"));
    vq.push_back(mk(0, 1, 0, 8'hF0, 0, 24'h00001C, 0, 0, 0, 1, "ext_brk_F0"));
    vq.push_back(mk(0, 1, 0, 8'h75, 1, 24'hE0F075, 1, 1, 0, 0, "ext_brk_75"));
    vq.push_back(mk(0, 0, 0, 8'h00, 0, 24'hE0F075, 1, 1, 0, 0, "single_pulse"));
    vq.push_back(mk(0, 1, 0, 8'hF0, 0, 24'hE0F075, 1, 1, 0, 1, "brk_F0"));
    vq.push_back(mk(0, 0, 1, 8'h00, 0, 24'hE0F075, 1, 1, 1, 0, "frame_err"));
    vq.push_back(mk(0, 1, 0, 8'h1C, 1, 24'h00001C, 0, 0, 0, 0, "after_err_1C"));
    vq.push_back(mk(0, 1, 0, 8'hF0, 0, 24'h00001C, 0, 0, 0, 1, "F0F0_a"));
    vq.push_back(mk(0, 1, 0, 8'hF0, 0, 24'h00001C, 0, 0, 1, 0, "F0F0_b"));
    vq.push_back(mk(0, 1, 0, 8'hE0, 0, 24'h00001C, 0, 0, 0, 1, "E0E0_a"));
    vq.push_back(mk(0, 1, 0, 8'hE0, 0, 24'h00001C, 0, 0, 1, 1, "E0E0_b"));
    vq.push_back(mk(0, 1, 0, 8'h6B, 1, 24'h00E06B, 0, 1, 0, 0, "E0E0_6B"));
    vq.push_back(mk(0, 1, 0, 8'hF0, 0, 24'h00E06B, 0, 1, 0, 1, "brk2_F0"));
    vq.push_back(mk(0, 1, 0, 8'h1C, 1, 24'h00F01C, 1, 0, 0, 0, "brk2_1C"));
    vq.push_back(mk(0, 1, 1, 8'h1C, 0, 24'h00F01C, 1, 0, 1, 0, "err_wins"));
    vq.push_back(mk(0, 1, 0, 8'hAA, 1, 24'h0000AA, 0, 0, 0, 0, "plain_AA"));
    vq.push_back(mk(0, 1, 0, 8'hFF, 1, 24'h0000FF, 0, 0, 0, 0, "plain_FF"));
    vq.push_back(mk(0, 1, 0, 8'h00, 1, 24'h000000, 0, 0, 0, 0, "plain_00"));
    vq.push_back(mk(0, 1, 0, 8'h5A, 1, 24'h00005A, 0, 0, 0, 0, "plain_5A"));
    vq.push_back(mk(0, 1, 0, 8'hE0, 0, 24'h00005A, 0, 0, 0, 1, "rst_seq_E0"));
    vq.push_back(mk(0, 1, 0, 8'hF0, 0, 24'h00005A, 0, 0, 0, 1, "rst_seq_F0"));
    vq.push_back(mk(1, 0, 0, 8'h00, 0, 24'h000000, 0, 0, 0, 0, "mid_rst"));
    vq.push_back(mk(0, 1, 0, 8'h73, 1, 24'h000073, 0, 0, 0, 0, "post_rst_73"));
    vq.push_back(mk(0, 1, 0, 8'hE0, 0, 24'h000073, 0, 0, 0, 1, "E0F0E0_a"));
    vq.push_back(mk(0, 1, 0, 8'hF0, 0, 24'h000073, 0, 0, 0, 1, "E0F0E0_b"));
    vq.push_back(mk(0, 1, 0, 8'hE0, 0, 24'h000073, 0, 0, 1, 0, "E0F0E0_c"));

    foreach (vq[i])
      step(vq[i].r, vq[i].v, vq[i].e, vq[i].d,
           {vq[i].kv, vq[i].kc, vq[i].kb, vq[i].ke, vq[i].se, vq[i].bz}, vq[i].name);

    // Timeout: E0 then idle; the error pulse is registered on the 16th edge after the strobe.
    step(0, 1, 0, 8'hE0, {1'b0, 24'h000073, 1'b0, 1'b0, 1'b0, 1'b1}, "to_E0");
    for (int i = 1; i <= TO; i++)
      step(0, 0, 0, 8'h00, {1'b0, 24'h000073, 1'b0, 1'b0, (i == TO), (i < TO)},
           $sformatf("to_idle_%0d", i));
    step(0, 0, 0, 8'h00, {1'b0, 24'h000073, 1'b0, 1'b0, 1'b0, 1'b0}, "to_pulse_end");
    step(0, 1, 0, 8'h75, {1'b1, 24'h000075, 1'b0, 1'b0, 1'b0, 1'b0}, "to_then_75");

    // A byte landing on the timeout cycle is processed instead of timing out.
    step(0, 1, 0, 8'hE0, {1'b0, 24'h000075, 1'b0, 1'b0, 1'b0, 1'b1}, "race_E0");
    for (int i = 1; i < TO; i++)
      step(0, 0, 0, 8'h00, {1'b0, 24'h000075, 1'b0, 1'b0, 1'b0, 1'b1},
           $sformatf("race_idle_%0d", i));
    step(0, 1, 0, 8'h6B, {1'b1, 24'h00E06B, 1'b0, 1'b1, 1'b0, 1'b0}, "race_6B");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
